apb_master_bridge: RTL and testbench

- Upstream neighbour of apb_slave: converts a simple valid/ready command interface from the local requester into APB transfers (IDLE/SETUP/ACCESS).
- Returns one response per command: read data, slave error flag, and a one-cycle completion pulse.
- One transfer outstanding at a time.
- Drives pclk-domain APB signals directly into apb_slave (psel, penable, pwrite, paddr, pwdata); samples prdata, pready, pslvrr.

---
 rtl/apb_master_bridge_if.sv | 31 +++
 rtl/apb_master_bridge.sv | 92 +++++++++
 tb/tb_apb_master_bridge.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command/response and APB signal bundle for apb_master_bridge.
// The master modport is the bridge view; the slave modport is the requester/APB-slave side.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslvrr;
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslvrr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslvrr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to APB IDLE/SETUP/ACCESS master, one transfer outstanding.
// APB_MASTER_TIMEOUT_EN bounds ACCESS wait states to TIMEOUT_CYC cycles and reports an error.
module apb_master_bridge #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input logic pclk,
   input logic preset,
   apb_master_bridge_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t            state_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0]     cnt_q;
`endif
   assign bus.cmd_ready = (state_q == IDLE) & !preset;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.cmd_valid) begin
               paddr_q   <= bus.cmd_addr;
               pwdata_q  <= bus.cmd_wdata;
               pwrite_q  <= bus.cmd_write;
               psel_q    <= 1'b1;
               penable_q <= 1'b0;
               state_q   <= SETUP;
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
               cnt_q     <= '0;
`endif
            end
            ACCESS: if (bus.pready) begin
               psel_q      <= 1'b0;
               penable_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= bus.pslvrr;
               rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
               state_q     <= IDLE;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            // this edge would bring the wait count to TIMEOUT_CYC
            else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               psel_q      <= 1'b0;
               penable_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b1;
               rsp_rdata_q <= '0;
               state_q     <= IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vectors for apb_master_bridge, checked on the falling edge.
module tb_apb_master_bridge;
   logic pclk = 1'b0;
   logic preset = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [31:0] last_rdata = '0;
   logic last_err = 1'b0;
   apb_master_bridge_if #(.ADDR_W(6), .DATA_W(32)) bus ();
   apb_master_bridge #(.ADDR_W(6), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .pclk(pclk),
      .preset(preset),
      .bus(bus)
   );
   always #5 pclk = ~pclk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic xfer(input logic w, input logic [5:0] a, input logic [31:0] d, input int waits,
                       input logic [31:0] rd, input logic err);
      @(negedge pclk);
      bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
      bus.pready = 1'b0; bus.pslvrr = 1'b1; bus.prdata = 32'hDEAD_BEEF;
      #1;
      chk("idle_ready", bus.cmd_ready, 1);
      chk("idle_psel", bus.psel, 0);
      chk("rsp_pulse_end", bus.rsp_valid, 0);
      chk("rsp_rdata_hold", bus.rsp_rdata, last_rdata);
      chk("rsp_err_hold", bus.rsp_err, last_err);
      @(negedge pclk);
      bus.cmd_valid = 1'b0; bus.cmd_wdata = ~d; bus.cmd_addr = ~a;
      chk("setup_psel", bus.psel, 1);
      chk("setup_penable", bus.penable, 0);
      chk("setup_ready", bus.cmd_ready, 0);
      for (int i = 0; i <= waits; i++) begin
         @(negedge pclk);
         chk("acc_psel", bus.psel, 1);
         chk("acc_penable", bus.penable, 1);
         chk("acc_paddr", bus.paddr, a);
         chk("acc_pwrite", bus.pwrite, w);
         chk("acc_pwdata", bus.pwdata, d);
         chk("acc_rsp", bus.rsp_valid, 0);
         bus.pready = (i == waits);
         bus.pslvrr = (i == waits) ? err : 1'b1;
         bus.prdata = (i == waits) ? rd : 32'hDEAD_BEEF;
      end
      @(negedge pclk);
      bus.pready = 1'b0; bus.pslvrr = 1'b1; bus.prdata = 32'hDEAD_BEEF;
      last_rdata = w ? 32'h0 : rd;
      last_err = err;
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_err", bus.rsp_err, last_err);
      chk("rsp_rdata", bus.rsp_rdata, last_rdata);
      chk("done_psel", bus.psel, 0);
      chk("done_penable", bus.penable, 0);
      chk("done_paddr_kept", bus.paddr, a);
   endtask
   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.prdata = '0; bus.pready = 1'b0; bus.pslvrr = 1'b0;
      repeat (3) @(negedge pclk);
      bus.cmd_valid = 1'b1;
      #1;
      chk("reset_ready", bus.cmd_ready, 0);
      chk("reset_psel", bus.psel, 0);
      chk("reset_penable", bus.penable, 0);
      chk("reset_paddr", bus.paddr, 0);
      chk("reset_pwdata", bus.pwdata, 0);
      chk("reset_rsp", bus.rsp_valid, 0);
      chk("reset_rdata", bus.rsp_rdata, 0);
      bus.cmd_valid = 1'b0;
      preset = 1'b0;
      // 1-3: basic write, waited read, error then clean completion
      xfer(1'b1, 6'h00, 32'hA5A5_1234, 0, 32'h0, 1'b0);
      xfer(1'b0, 6'h00, 32'h0, 2, 32'hA5A5_1234, 1'b0);
      xfer(1'b1, 6'h3F, 32'h0BAD_F00D, 0, 32'h0, 1'b1);
      xfer(1'b0, 6'h3F, 32'h0, 1, 32'h1357_9BDF, 1'b0);
      begin : queued
         int hs = 0, rsps = 0, bad_ready = 0, hs_busy = 0;
         @(negedge pclk);
         bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h04; bus.cmd_wdata = 32'h11;
         bus.pready = 1'b1; bus.pslvrr = 1'b0; bus.prdata = 32'h11;
         for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.rsp_valid) rsps++;
            if (bus.psel && bus.cmd_ready) bad_ready++;
            if (bus.cmd_valid && bus.cmd_ready) begin
               hs++;
               if (bus.psel) hs_busy++;
            end
            @(negedge pclk);
            if (hs == 1) begin bus.cmd_write = 1'b0; bus.cmd_wdata = 32'hFFFF_FFFF; end
            if (hs == 2) bus.cmd_valid = 1'b0;
         end
         chk("q_handshakes", hs, 2);
         chk("q_rsp_pulses", rsps, 2);
         chk("q_ready_busy", bad_ready, 0);
         chk("q_no_gap", hs_busy, 0);
         chk("q_rdata", bus.rsp_rdata, 32'h11);
         bus.pready = 1'b0; bus.pslvrr = 1'b1;
         last_rdata = 32'h11; last_err = 1'b0;
      end
      // 5: reset during ACCESS with pready low
      @(negedge pclk);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'h2A;
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      repeat (3) @(negedge pclk);
      chk("abort_in_access", bus.penable, 1);
      preset = 1'b1;
      #1;
      chk("abort_ready_rst", bus.cmd_ready, 0);
      @(negedge pclk);
      preset = 1'b0;
      #1;
      chk("abort_psel", bus.psel, 0);
      chk("abort_penable", bus.penable, 0);
      chk("abort_rsp", bus.rsp_valid, 0);
      chk("abort_ready", bus.cmd_ready, 1);
      last_rdata = '0; last_err = 1'b0;
      xfer(1'b0, 6'h05, 32'h0, 0, 32'hCAFE_0005, 1'b0);
      // 6: slave never asserts pready
      begin : stall
         int acc = 0, rsps = 0, dropped = 0;
         logic err_seen = 1'b0;
         @(negedge pclk);
         bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h10; bus.cmd_wdata = 32'h77;
         bus.pready = 1'b0;
         @(negedge pclk);
         bus.cmd_valid = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid) begin rsps++; err_seen = bus.rsp_err; end
            if (rsps == 0 && bus.psel && bus.penable) acc++;
            if (rsps == 0 && !(bus.psel && bus.penable)) dropped++;
         end
`ifdef APB_MASTER_TIMEOUT_EN
         chk("to_access_cycles", acc, 16);
         chk("to_rsp", rsps, 1);
         chk("to_err", err_seen, 1);
         chk("to_rdata", bus.rsp_rdata, 0);
         chk("to_psel", bus.psel, 0);
         chk("to_dropped", dropped, 0);
`else
         chk("stall_access_cycles", acc, 100);
         chk("stall_rsp", rsps, 0);
         chk("stall_psel", bus.psel, 1);
         chk("stall_err_idle", err_seen, 0);
`endif
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
